// File: rtl/ahb_arb_pkg.sv
// Shared AHB arbiter types and constants.
package ahb_arb_pkg;

    localparam int unsigned HRESP_W     = 2;
    localparam int unsigned MAX_MASTERS = 16;

    typedef enum logic [HRESP_W-1:0] {
        HrespOkay  = 2'b00,
        HrespError = 2'b01,
        HrespRetry = 2'b10,
        HrespSplit = 2'b11
    } hresp_e;

    typedef enum logic [1:0] {
        HtransIdle   = 2'b00,
        HtransBusy   = 2'b01,
        HtransNonseq = 2'b10,
        HtransSeq    = 2'b11
    } htrans_e;

endpackage

// File: rtl/ahb_arb_pick.sv
// Combinational grant picker: fixed priority (lowest index) or round-robin
// searching upward from rr_ptr_i + 1 via a double-width rotate.
module ahb_arb_pick #(
    parameter int unsigned  N    = 4,
    parameter int unsigned  MODE = 1,
    localparam int unsigned MW   = $clog2(N)
) (
    input  logic [N-1:0]  elig_i,
    input  logic [MW-1:0] rr_ptr_i,
    output logic [N-1:0]  pick_oh_o,
    output logic [MW-1:0] pick_idx_o
);

    logic [N-1:0] rot;
    logic         found;
    int unsigned  start;
    int unsigned  off;
    int unsigned  idx;

    always_comb begin
        if (MODE == 0) begin
            start = 0;
        end else begin
            start = 32'(rr_ptr_i) + 1;
        end
        if (start >= N) begin
            start = 0;
        end
        rot   = N'({elig_i, elig_i} >> start);
        off   = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (rot[i] && !found) begin
                off   = i;
                found = 1'b1;
            end
        end
        idx = start + off;
        if (idx >= N) begin
            idx = idx - N;
        end
        pick_idx_o = MW'(idx);
        pick_oh_o  = {{(N-1){1'b0}}, 1'b1} << idx;
    end

endmodule

// File: rtl/ahb_arbiter_rr.sv
// AHB bus arbiter for N masters: lock retention, bounded hold, SPLIT masking and a
// default master; HMASTER/HMASTLOCK track the data-phase owner one arbitration point late.
module ahb_arbiter_rr
    import ahb_arb_pkg::*;
#(
    parameter int unsigned  NUM_MASTERS    = 4,
    parameter int unsigned  MODE           = 1,
    parameter int unsigned  DEFAULT_MASTER = 0,
    parameter int unsigned  MAX_HOLD       = 8,
    localparam int unsigned MW             = $clog2(NUM_MASTERS)
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQx,
    input  logic [NUM_MASTERS-1:0] HLOCKx,
    input  logic [NUM_MASTERS-1:0] HSPLIT,
    input  logic                   HREADY,
    input  logic [HRESP_W-1:0]     HRESP,
    output logic [NUM_MASTERS-1:0] HGRANTx,
    output logic [MW-1:0]          HMASTER,
    output logic                   HMASTLOCK
);

    localparam int unsigned HW = $clog2(MAX_HOLD + 1);
    localparam logic [MW-1:0] DefIdx = MW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DefOh =
        {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
    localparam logic [HW-1:0] HoldLast = HW'(MAX_HOLD - 1);

    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [MW-1:0]          gidx_q, gidx_d;
    logic [MW-1:0]          hmaster_q, hmaster_d;
    logic                   hmastlock_q, hmastlock_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [MW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [NUM_MASTERS-1:0] split_q, split_d;

    logic [NUM_MASTERS-1:0] elig, others, cand, pick_oh;
    logic [MW-1:0]          pick_idx;

    assign elig   = HBUSREQx & ~split_q;
    // On a re-pick the current owner only wins if nobody else is eligible; this is what
    // lets hold expiry hand the bus on in fixed-priority mode too.
    assign others = elig & ~grant_q;
    assign cand   = (|others) ? others : elig;

    ahb_arb_pick #(
        .N    (NUM_MASTERS),
        .MODE (MODE)
    ) u_pick (
        .elig_i     (cand),
        .rr_ptr_i   (rr_ptr_q),
        .pick_oh_o  (pick_oh),
        .pick_idx_o (pick_idx)
    );

    always_comb begin
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        hold_d      = hold_q;
        rr_ptr_d    = rr_ptr_q;

        // Set after clear so a same-cycle set/clear of one bit leaves it set.
        split_d = split_q & ~HSPLIT;
        if (hresp_e'(HRESP) == HrespSplit && !HREADY) begin
            split_d[hmaster_q] = 1'b1;
        end

        if (HREADY) begin
            hmaster_d   = gidx_q;
            hmastlock_d = HLOCKx[gidx_q] & HBUSREQx[gidx_q];
            if (HLOCKx[gidx_q] && elig[gidx_q]) begin
                grant_d = grant_q;
            end else if (elig[gidx_q] && hold_q < HoldLast) begin
                hold_d = hold_q + HW'(1);
            end else if (|elig) begin
                grant_d  = pick_oh;
                gidx_d   = pick_idx;
                hold_d   = '0;
                rr_ptr_d = pick_idx;
            end else begin
                grant_d = DefOh;
                gidx_d  = DefIdx;
                hold_d  = '0;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            grant_q     <= DefOh;
            gidx_q      <= DefIdx;
            hmaster_q   <= DefIdx;
            hmastlock_q <= 1'b0;
            hold_q      <= '0;
            rr_ptr_q    <= DefIdx;
            split_q     <= '0;
        end else begin
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
            hold_q      <= hold_d;
            rr_ptr_q    <= rr_ptr_d;
            split_q     <= split_d;
        end
    end

    assign HGRANTx   = grant_q;
    assign HMASTER   = hmaster_q;
    assign HMASTLOCK = hmastlock_q;

endmodule
